// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op and state
// encodings, default width and small op-decode helpers.
package mul_div_unit_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    MDU_MUL   = 3'b000,
    MDU_MULH  = 3'b001,
    MDU_MULHU = 3'b010,
    MDU_MULX  = 3'b011,
    MDU_DIV   = 3'b100,
    MDU_DIVU  = 3'b101,
    MDU_REM   = 3'b110,
    MDU_REMU  = 3'b111
  } mduOp_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mduState_e;

  function automatic logic isDivOp(input mduOp_e op);
    return op[2];
  endfunction

  // Only these ops interpret operands as two's complement; 011 falls back to MUL.
  function automatic logic isSignedOp(input mduOp_e op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division iteration on a {rem,quot} register: shift left,
// trial-subtract the divisor from the remainder, set the quotient bit on success.
module mul_div_unit_div_step
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [2*DATA_WIDTH-1:0] remQuot,
  input  logic [DATA_WIDTH-1:0]   divisor,
  output logic [2*DATA_WIDTH-1:0] remQuotNext
);

  logic [DATA_WIDTH:0]   remShift;
  logic [DATA_WIDTH-1:0] remDiff;

  always_comb begin
    // Remainder is always below the divisor, so the shifted value needs one extra bit.
    remShift = remQuot[2*DATA_WIDTH-1:DATA_WIDTH-1];
    remDiff  = remShift[DATA_WIDTH-1:0] - divisor;
    if (remShift >= {1'b0, divisor}) begin
      remQuotNext = {remDiff, remQuot[DATA_WIDTH-2:0], 1'b1};
    end else begin
      remQuotNext = {remShift[DATA_WIDTH-1:0], remQuot[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle integer multiply/divide unit: one bit per cycle on magnitudes,
// sign and divide-by-zero fix-up in a single FIX cycle, valid/ready on both sides.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [2:0]            MDUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  DivZero
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W);

  mduState_e        stateQ, stateD;
  logic [CNT_W-1:0] counter;
  mduOp_e           opQ, opIn;
  logic [W-1:0]     aRaw, opnd, addend, resFix;
  logic             sA, sB, dzFix, accept, opSigned;
  logic [2*W-1:0]   acc, accMul, accDiv, prodFixed;
  logic [W:0]       mulSum;

  function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v, input logic isSigned);
    return (isSigned && (v < 0)) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [W-1:0] applySign(input logic [W-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  assign opIn     = mduOp_e'(MDUop);
  assign opSigned = isSignedOp(opIn);
  assign accept   = in_valid && in_ready;

  always_comb begin
    stateD    = stateQ;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (stateQ)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) stateD = CALC;
      end
      CALC: if (counter == '0) stateD = FIX;
      FIX:  stateD = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  mul_div_unit_div_step #(.DATA_WIDTH(W)) uDivStep (
    .remQuot    (acc),
    .divisor    (opnd),
    .remQuotNext(accDiv)
  );

  // Multiply: acc = {partial, multiplier}; add multiplicand on lsb, shift right with carry.
  always_comb begin
    addend    = acc[0] ? opnd : {W{1'b0}};
    mulSum    = {1'b0, acc[2*W-1:W]} + {1'b0, addend};
    accMul    = {mulSum, acc[W-1:1]};
    prodFixed = (sA ^ sB) ? (~acc + 1'b1) : acc;
    dzFix     = isDivOp(opQ) && (opnd == '0);
    case (opQ)
      MDU_MULH, MDU_MULHU: resFix = prodFixed[2*W-1:W];
      MDU_DIV, MDU_DIVU:   resFix = dzFix ? {W{1'b1}} : applySign(acc[W-1:0], sA ^ sB);
      MDU_REM, MDU_REMU:   resFix = dzFix ? aRaw : applySign(acc[2*W-1:W], sA);
      default:             resFix = acc[W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stateQ  <= IDLE;
      counter <= '0;
      Result  <= '0;
      DivZero <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        counter <= CNT_W'(W - 1);
      end else if ((stateQ == CALC) && (counter != '0)) begin
        counter <= counter - CNT_W'(1);
      end
      if (stateQ == FIX) begin
        Result  <= resFix;
        DivZero <= dzFix;
      end
    end
  end

  // Operand and accumulator registers carry no reset; they are always loaded at accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      opQ  <= opIn;
      aRaw <= A;
      sA   <= opSigned & A[W-1];
      sB   <= opSigned & B[W-1];
      if (isDivOp(opIn)) begin
        opnd <= magnitude(B, opSigned);
        acc  <= {{W{1'b0}}, magnitude(A, opSigned)};
      end else begin
        opnd <= magnitude(A, opSigned);
        acc  <= {{W{1'b0}}, magnitude(B, opSigned)};
      end
    end else if (stateQ == CALC) begin
      acc <= isDivOp(opQ) ? accDiv : accMul;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed literal cases, handshake/reset scenarios and
// randomized ops scored against a plain-arithmetic reference model.
module tb_mul_div_unit;

  localparam int  W    = 32;
  localparam int  PER  = 10;
  localparam longint LAT = (W + 1) * PER + PER / 2;
  localparam longint THR = (W + 3) * PER;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [2:0]    MDUop = 3'b000;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  Result;
  logic          DivZero;

  int nAssert = 0;
  int nFail   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
    time          t;
  } exp_t;
  exp_t expQ[$];

  logic prevValid = 1'b0;
  logic randRdy   = 1'b0;
  logic rdyHold   = 1'b1;
  time  lastAcceptT = 0;

  always #(PER / 2) clk = ~clk;

  mul_div_unit #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .MDUop    (MDUop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result   (Result),
    .DivZero  (DivZero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nAssert++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic dz);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic               ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    dz  = 1'b0;
    r   = '0;
    case (op)
      3'b001: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r  = sp[63:32];
      end
      3'b010: begin
        up = {32'b0, a} * {32'b0, b};
        r  = up[63:32];
      end
      3'b100: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
        else if (ovf) r = 32'h8000_0000;
        else r = $signed(a) / $signed(b);
      end
      3'b101: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
        else r = a / b;
      end
      3'b110: begin
        if (b == 0) begin r = a; dz = 1'b1; end
        else if (ovf) r = 32'h0;
        else r = $signed(a) % $signed(b);
      end
      3'b111: begin
        if (b == 0) begin r = a; dz = 1'b1; end
        else r = a % b;
      end
      default: begin
        up = {32'b0, a} * {32'b0, b};
        r  = up[31:0];
      end
    endcase
  endfunction

  task automatic pin(input string name, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] er, input logic edz);
    logic [W-1:0] r;
    logic         dz;
    model(op, a, b, r, dz);
    check({"model ", name}, r, er);
    check({"model dz ", name}, dz, edz);
  endtask

  // Drive a request until accepted; the expectation is queued with the accept edge time.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic edz);
    logic got;
    int   g;
    got = 1'b0;
    in_valid = 1'b1;
    MDUop = op;
    A = a;
    B = b;
    for (g = 0; g < 500; g++) begin
      got = in_ready;
      @(posedge clk);
      if (got) break;
      #1;
    end
    check("accept within bound", got, 1'b1);
    if (got) begin
      lastAcceptT = $time;
      expQ.push_back('{er, edz, $time});
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic issueModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         dz;
    model(op, a, b, r, dz);
    issue(op, a, b, r, dz);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (((expQ.size() != 0) || out_valid) && (g < 5000)) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("drain within bound", (g < 5000), 1'b1);
  endtask

  function automatic logic [W-1:0] pickVal();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(15));
      default: return W'($urandom);
    endcase
  endfunction

  always @(posedge clk) begin
    #1 out_ready = randRdy ? ($urandom_range(3) != 0) : rdyHold;
  end

  always @(negedge clk) begin
    if (!resetn) begin
      prevValid = 1'b0;
    end else begin
      if (out_valid) begin
        if (expQ.size() == 0) begin
          check("no response expected", out_valid, 1'b0);
        end else begin
          check("Result", Result, expQ[0].res);
          check("DivZero", DivZero, expQ[0].dz);
          if (!prevValid) check("latency", 64'($time - expQ[0].t), LAT);
          if (out_ready) void'(expQ.pop_front());
        end
      end
      prevValid = out_valid && !out_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    time tA, tH;
    logic hs;
    int   g;

    pin("MUL 7*6",        3'b000, 32'd7,          32'd6,          32'd42,         1'b0);
    pin("MULHU max*max",  3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0);
    pin("MULH -1*2",      3'b001, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  1'b0);
    pin("MULH min*min",   3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  1'b0);
    pin("DIV -7/2",       3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0);
    pin("REM -7/2",       3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0);
    pin("DIVU 100/7",     3'b101, 32'd100,        32'd7,          32'd14,         1'b0);
    pin("REMU 100/7",     3'b111, 32'd100,        32'd7,          32'd2,          1'b0);
    pin("DIVU 5/0",       3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1);
    pin("REM x/0",        3'b110, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b1);
    pin("DIV ovf",        3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0);

    #12;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset Result", Result, 32'h0);
    check("reset DivZero", DivZero, 1'b0);
    @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;

    issue(3'b000, 32'd7, 32'd6, 32'd42, 1'b0);
    tA = lastAcceptT;
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    check("back-to-back spacing", 64'(lastAcceptT - tA), THR);
    issue(3'b001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
    issue(3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
    issue(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    issue(3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    issue(3'b011, 32'd9, 32'd5, 32'd45, 1'b0);
    issue(3'b000, 32'd3, 32'd0, 32'd0, 1'b0);
    drain();

    // Busy request is ignored; consumer stall keeps the response stable.
    rdyHold = 1'b0;
    @(posedge clk);
    #1;
    issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
    in_valid = 1'b1;
    MDUop = 3'b000;
    A = 32'd5;
    B = 32'd5;
    repeat (5) begin
      @(negedge clk);
      check("in_ready while busy", in_ready, 1'b0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    g = 0;
    while (!out_valid && (g < 100)) begin
      @(posedge clk);
      #2;
      g++;
    end
    check("stall reaches DONE", out_valid, 1'b1);
    repeat (10) begin
      @(negedge clk);
      check("stall Result stable", Result, 32'd14);
      check("stall out_valid held", out_valid, 1'b1);
    end
    rdyHold = 1'b1;
    g = 0;
    hs = 1'b0;
    while (!hs && (g < 10)) begin
      @(negedge clk);
      hs = out_valid && out_ready;
      g++;
    end
    check("handshake seen", hs, 1'b1);
    @(posedge clk);
    tH = $time;
    #2;
    check("idle after handshake in_ready", in_ready, 1'b1);
    check("idle after handshake out_valid", out_valid, 1'b0);
    issue(3'b000, 32'd3, 32'd4, 32'd12, 1'b0);
    check("accept one cycle after handshake", 64'(lastAcceptT - tH), 64'(PER));
    drain();

    // Abort mid-calculation with reset.
    issueModel(3'b000, 32'h0001_2345, 32'h0000_0777);
    repeat (12) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("abort out_valid", out_valid, 1'b0);
    check("abort in_ready", in_ready, 1'b1);
    check("abort Result", Result, 32'h0);
    check("abort DivZero", DivZero, 1'b0);
    expQ.delete();
    @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;
    issue(3'b000, 32'd3, 32'd3, 32'd9, 1'b0);
    drain();
    repeat (40) @(posedge clk);
    #1;

    randRdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      issueModel(3'($urandom_range(7)), pickVal(), pickVal());
    end
    drain();
    randRdy = 1'b0;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
